// File: rtl/rle_dpcm_block_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rle_dpcm_block_decoder                                        |
// | Function : DPCM DC + RLE AC decode of one 8x8 block, raster-order output |
// | Options  : DECODER_RESTART_EN adds a 'restart' port clearing the DC pred |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rle_dpcm_block_decoder #(
  parameter int COEF_W = 11,
  parameter int DPCM_W = 10,
  parameter int RLE_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
`ifdef DECODER_RESTART_EN
  input  logic              restart,
`endif
  input  logic [DPCM_W-1:0] dpcm_in,
  input  logic              dpcm_valid,
  output logic              dpcm_ready,
  input  logic [RLE_W-1:0]  rle_in,
  input  logic              rle_valid,
  output logic              rle_ready,
  output logic [COEF_W-1:0] coef_out,
  output logic [5:0]        coef_idx,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              coef_last,
  output logic              err
);

  localparam int c_LVL_W = RLE_W - 4;

  // raster index -> zig-zag position
  localparam logic [5:0] c_zigzag [64] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    S_DC  = 2'd0,
    S_AC  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t              r_state;
  logic [COEF_W-1:0]   r_pred;
  logic [6:0]          r_pos;
  logic [63:0]         r_mask;
  logic [COEF_W-1:0]   r_buf [64];

  logic [3:0]          w_run;
  logic [c_LVL_W-1:0]  w_level;
  logic                w_dc_acc, w_ac_acc, w_eob, w_zrl, w_ovf, w_wr, w_ac_done;
  logic [6:0]          w_t, w_zrl_pos;
  logic [COEF_W-1:0]   w_pred_base, w_dc, w_lvl_ext, w_rd_val;
  logic [5:0]          w_rd_k, w_rd_zz;

  assign w_run     = rle_in[RLE_W-1 -: 4];
  assign w_level   = rle_in[c_LVL_W-1:0];
  assign w_dc_acc  = (r_state == S_DC) && dpcm_valid && dpcm_ready;
  assign w_ac_acc  = (r_state == S_AC) && rle_valid && rle_ready;
  assign w_eob     = (w_run == 4'd0)  && (w_level == '0);
  assign w_zrl     = (w_run == 4'd15) && (w_level == '0);
  assign w_t       = r_pos + {3'b000, w_run};
  assign w_zrl_pos = r_pos + 7'd16;
  assign w_ovf     = w_zrl ? (w_zrl_pos > 7'd63) : (w_t > 7'd63);
  assign w_wr      = w_ac_acc && !w_eob && !w_zrl && (w_t <= 7'd63);
  assign w_ac_done = w_ac_acc && (w_eob || w_ovf || (!w_zrl && w_t == 7'd63));

`ifdef DECODER_RESTART_EN
  assign w_pred_base = restart ? '0 : r_pred;
`else
  assign w_pred_base = r_pred;
`endif
  assign w_dc      = w_pred_base + {{(COEF_W-DPCM_W){dpcm_in[DPCM_W-1]}}, dpcm_in};
  assign w_lvl_ext = {{(COEF_W-c_LVL_W){w_level[c_LVL_W-1]}}, w_level};

  // Read port looks one beat ahead so coef_out can be registered.
  assign w_rd_k   = (r_state == S_OUT) ? coef_idx + 6'd1 : 6'd0;
  assign w_rd_zz  = c_zigzag[w_rd_k];
  assign w_rd_val = r_mask[w_rd_zz] ? r_buf[w_rd_zz] : '0;

  always_ff @(posedge clk) begin
    if (w_dc_acc) r_buf[0] <= w_dc;
    if (w_wr)     r_buf[w_t[5:0]] <= w_lvl_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_DC;
      r_pred     <= '0;
      r_pos      <= '0;
      r_mask     <= '0;
      dpcm_ready <= 1'b0;
      rle_ready  <= 1'b0;
      coef_out   <= '0;
      coef_idx   <= '0;
      coef_valid <= 1'b0;
      coef_last  <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        S_DC: begin
          dpcm_ready <= 1'b1;
`ifdef DECODER_RESTART_EN
          if (restart) r_pred <= '0;
`endif
          if (w_dc_acc) begin
            r_pred     <= w_dc;
            r_pos      <= 7'd1;
            r_mask     <= 64'd1;
            dpcm_ready <= 1'b0;
            rle_ready  <= 1'b1;
            r_state    <= S_AC;
          end
        end
        S_AC: begin
          if (w_wr) begin
            r_mask[w_t[5:0]] <= 1'b1;
            r_pos            <= w_t + 7'd1;
          end else if (w_ac_acc && w_zrl && !w_ovf) begin
            r_pos <= w_zrl_pos;
          end
          if (w_ac_acc && w_ovf) err <= 1'b1;
          if (w_ac_done) begin
            rle_ready  <= 1'b0;
            r_state    <= S_OUT;
            coef_valid <= 1'b1;
            coef_idx   <= 6'd0;
            coef_out   <= w_rd_val;
            coef_last  <= 1'b0;
          end
        end
        S_OUT: begin
          // coef_valid stays high for the whole of S_OUT
          if (coef_ready) begin
            if (coef_last) begin
              coef_valid <= 1'b0;
              coef_last  <= 1'b0;
              dpcm_ready <= 1'b1;
              r_state    <= S_DC;
            end else begin
              coef_idx  <= coef_idx + 6'd1;
              coef_out  <= w_rd_val;
              coef_last <= (coef_idx == 6'd62);
            end
          end
        end
        default: r_state <= S_DC;
      endcase
    end
  end

endmodule
`default_nettype wire
